// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receive frame engine.
// Synchronizes rx, detects the start-bit falling edge, samples every bit at
// mid-bit with an internal baud counter and deserializes 8N1 frames LSB first.
// Optional even-parity (8E1) support is compiled in when the macro
// UART_RX_PARITY_EN is defined; otherwise parity_err is tied low.
module uart_rx_frame #(
    parameter int CLK_FREQUENCE = 50_000_000,
    parameter int BAUD_RATE     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       rx_busy
);

    localparam int BPS_CNT  = CLK_FREQUENCE / BAUD_RATE - 1;
    localparam int HALF_CNT = BPS_CNT / 2;
    localparam int BPS_WD   = $clog2(BPS_CNT + 1);

    localparam logic [BPS_WD-1:0] BPS_LAST  = BPS_WD'(BPS_CNT);
    localparam logic [BPS_WD-1:0] HALF_LAST = BPS_WD'(HALF_CNT);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state_reg, state_next;
    logic [BPS_WD-1:0] count_reg, count_next;
    logic [2:0]        bit_idx_reg, bit_idx_next;
    logic [7:0]        shift_reg, shift_next;
    logic [7:0]        rx_data_reg, rx_data_next;
    logic              rx_valid_reg, rx_valid_next;
    logic              frame_err_reg, frame_err_next;

    logic              rx_meta_reg, rx_s_reg, rx_d_reg;

`ifdef UART_RX_PARITY_EN
    logic              parity_bit_reg, parity_bit_next;
    logic              parity_err_reg, parity_err_next;
`endif

    // Two-flop synchronizer for the async line plus a delay flop for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
            rx_d_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
            rx_d_reg    <= rx_s_reg;
        end
    end

    // FSM state, baud counter, shift register and registered output strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_reg <= 1'b0;
            parity_err_reg <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            bit_idx_reg    <= bit_idx_next;
            shift_reg      <= shift_next;
            rx_data_reg    <= rx_data_next;
            rx_valid_reg   <= rx_valid_next;
            frame_err_reg  <= frame_err_next;
`ifdef UART_RX_PARITY_EN
            parity_bit_reg <= parity_bit_next;
            parity_err_reg <= parity_err_next;
`endif
        end
    end

    // Next-state logic: half-bit wait in START, then one full bit period per sample.
    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        bit_idx_next    = bit_idx_reg;
        shift_next      = shift_reg;
        rx_data_next    = rx_data_reg;
        rx_valid_next   = 1'b0;
        frame_err_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bit_next = parity_bit_reg;
        parity_err_next = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                count_next = '0;
                if (rx_d_reg && !rx_s_reg) begin
                    state_next = START;
                end
            end
            START: begin
                if (count_reg == HALF_LAST) begin
                    count_next = '0;
                    if (!rx_s_reg) begin
                        state_next   = DATA;
                        bit_idx_next = '0;
                    end else begin
                        // Line went back high before mid-start: treat as a glitch.
                        state_next = IDLE;
                    end
                end else begin
                    count_next = count_reg + BPS_WD'(1);
                end
            end
            DATA: begin
                if (count_reg == BPS_LAST) begin
                    count_next              = '0;
                    shift_next[bit_idx_reg] = rx_s_reg;
                    bit_idx_next            = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end else begin
                    count_next = count_reg + BPS_WD'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (count_reg == BPS_LAST) begin
                    count_next      = '0;
                    parity_bit_next = rx_s_reg;
                    state_next      = STOP;
                end else begin
                    count_next = count_reg + BPS_WD'(1);
                end
            end
`endif
            STOP: begin
                if (count_reg == BPS_LAST) begin
                    // Leave at mid-stop so a start bit half a bit later is still caught.
                    count_next = '0;
                    state_next = IDLE;
                    if (rx_s_reg) begin
                        rx_data_next  = shift_reg;
                        rx_valid_next = 1'b1;
                    end else begin
                        frame_err_next = 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
                    parity_err_next = (parity_bit_reg != ^shift_reg);
`endif
                end else begin
                    count_next = count_reg + BPS_WD'(1);
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign frame_err = frame_err_reg;
    assign rx_busy   = (state_reg != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_reg;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed frames against an event-queue model of the receiver.
// Uses a short bit period (20 clk/bit) so the whole run stays small.
// Define UART_RX_PARITY_EN for the 8E1 build.
module tb_uart_rx_frame;

    localparam int CLK_F   = 2_000_000;
    localparam int BAUD    = 100_000;
    localparam int BIT_CLK = CLK_F / BAUD;        // 20 clocks per bit
    localparam int BPS     = BIT_CLK - 1;
    localparam int HALF    = BPS / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS   = 10;                  // 8 data + parity + stop
    localparam int LAT_LIT = 213;
`else
    localparam int NBITS   = 9;                   // 8 data + stop
    localparam int LAT_LIT = 193;
`endif
    // Start-edge to strobe latency: sync(2) + edge(1) + half bit + sampled bits.
    localparam int LAT = 2 + 1 + HALF + 1 + NBITS * BIT_CLK;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       rx_busy;

    uart_rx_frame #(
        .CLK_FREQUENCE(CLK_F),
        .BAUD_RATE    (BAUD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .rx_busy   (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint     cyc;
        bit         is_err;
        logic [7:0] data;
        logic       perr;
    } ev_t;

    ev_t        evq[$];
    longint     cyc = 0;
    int         checks = 0;
    int         failures = 0;
    bit         cmp_en = 1'b0;
    logic [7:0] model_data = 8'h00;
    int         n_valid = 0;
    int         n_ferr = 0;
    int         n_both = 0;
    longint     last_valid_cyc = 0;
    longint     last_edge_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison of the strobes and held data against the event queue.
    always @(negedge clk) begin
        if (cmp_en) begin
            logic exp_v, exp_f, exp_p;
            ev_t  ev;
            exp_v = 1'b0;
            exp_f = 1'b0;
            exp_p = 1'b0;
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                ev = evq.pop_front();
                chk("missed_event", 32'(cyc), 32'(ev.cyc));
            end
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                ev = evq.pop_front();
                if (ev.is_err) exp_f = 1'b1;
                else begin
                    exp_v      = 1'b1;
                    model_data = ev.data;
                end
                exp_p = ev.perr;
            end
            chk("rx_valid", 32'(rx_valid), 32'(exp_v));
            chk("frame_err", 32'(frame_err), 32'(exp_f));
            chk("parity_err", 32'(parity_err), 32'(exp_p));
            chk("rx_data", 32'(rx_data), 32'(model_data));
            if (rx_valid) begin
                n_valid++;
                last_valid_cyc = cyc;
            end
            if (frame_err) n_ferr++;
            if (rx_valid && parity_err) n_both++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one full frame and queue the outcome the receiver must produce.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par);
        ev_t  ev;
        logic par;
        par = ^d ^ bad_par;
        rx = 1'b0;
        last_edge_cyc = cyc;
        ev.cyc    = cyc + LAT;
        ev.is_err = !stop_bit;
        ev.data   = d;
`ifdef UART_RX_PARITY_EN
        ev.perr   = bad_par;
`else
        ev.perr   = 1'b0;
`endif
        evq.push_back(ev);
        $display("frame data=%02h stop=%0b bad_par=%0b edge_cycle=%0d", d, stop_bit, bad_par, cyc);
        wait_clk(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clk(BIT_CLK);
        end
`ifdef UART_RX_PARITY_EN
        rx = par;
        wait_clk(BIT_CLK);
`endif
        rx = stop_bit;
        wait_clk(BIT_CLK);
        rx = 1'b1;
    endtask

    initial begin
        int v0;
        rx    = 1'b1;
        rst_n = 1'b0;
        wait_clk(4);
        rst_n = 1'b1;
        model_data = 8'h00;
        cmp_en = 1'b1;

        // 1: long idle after reset
        chk("reset_busy", 32'(rx_busy), 32'd0);
        chk("reset_data", 32'(rx_data), 32'h00);
        wait_clk(20000);
        chk("idle_busy", 32'(rx_busy), 32'd0);
        chk("idle_no_valid", 32'(n_valid), 32'd0);
        chk("idle_data", 32'(rx_data), 32'h00);
        $display("idle 20000 cycles done valid_pulses=%0d", n_valid);

        // 2: one good frame, with latency pinned to a hand-computed literal
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_clk(3 * BIT_CLK);
        chk("a5_pulses", 32'(n_valid), 32'd1);
        chk("a5_data", 32'(rx_data), 32'hA5);
        chk("a5_latency", 32'(last_valid_cyc - last_edge_cyc), 32'(LAT_LIT));
        chk("a5_no_ferr", 32'(n_ferr), 32'd0);

        // 3: stop bit forced low
        v0 = n_valid;
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_clk(3 * BIT_CLK);
        chk("3c_ferr", 32'(n_ferr), 32'd1);
        chk("3c_no_valid", 32'(n_valid - v0), 32'd0);
        chk("3c_data_kept", 32'(rx_data), 32'hA5);

        // 4: short glitch rejected, then a good frame
        rx = 1'b0;
        wait_clk(5);
        rx = 1'b1;
        wait_clk(4);
        chk("glitch_busy", 32'(rx_busy), 32'd1);
        wait_clk(5 * BIT_CLK);
        chk("glitch_idle", 32'(rx_busy), 32'd0);
        $display("glitch 5 cycles done valid_pulses=%0d", n_valid);
        v0 = n_valid;
        send_frame(8'h5A, 1'b1, 1'b0);
        wait_clk(3 * BIT_CLK);
        chk("5a_pulses", 32'(n_valid - v0), 32'd1);
        chk("5a_data", 32'(rx_data), 32'h5A);

        // 5: back-to-back frames with no idle between them
        v0 = n_valid;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        wait_clk(3 * BIT_CLK);
        chk("b2b_pulses", 32'(n_valid - v0), 32'd2);
        chk("b2b_data", 32'(rx_data), 32'hFF);

        // 6: reset during D3 (line high) abandons the frame
        v0 = n_valid;
        rx = 1'b0;
        $display("partial frame, reset during D3 edge_cycle=%0d", cyc);
        wait_clk(4 * BIT_CLK);
        rx = 1'b1;
        wait_clk(BIT_CLK / 2);
        chk("d3_busy", 32'(rx_busy), 32'd1);
        cmp_en = 1'b0;
        rst_n  = 1'b0;
        wait_clk(1);
        rst_n  = 1'b1;
        evq.delete();
        model_data = 8'h00;
        chk("rst_busy", 32'(rx_busy), 32'd0);
        chk("rst_data", 32'(rx_data), 32'h00);
        cmp_en = 1'b1;
        wait_clk(12 * BIT_CLK);
        chk("rst_no_strobe", 32'(n_valid - v0), 32'd0);
        send_frame(8'h81, 1'b1, 1'b0);
        wait_clk(3 * BIT_CLK);
        chk("81_pulses", 32'(n_valid - v0), 32'd1);
        chk("81_data", 32'(rx_data), 32'h81);

`ifdef UART_RX_PARITY_EN
        // 7: wrong parity still delivers the byte
        v0 = n_valid;
        send_frame(8'h07, 1'b1, 1'b1);
        wait_clk(3 * BIT_CLK);
        chk("07_pulses", 32'(n_valid - v0), 32'd1);
        chk("07_both", 32'(n_both), 32'd1);
        chk("07_data", 32'(rx_data), 32'h07);
`else
        chk("no_parity_pulse", 32'(n_both), 32'd0);
`endif

        wait_clk(50);
        chk("queue_drained", 32'(evq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
